mtm_alu_deserializer: RTL and testbench
=======================================

MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sin  in  1  serial input, idle high, one bit per clk.
- A  out  32  operand A of last valid packet.
- B  out  32  operand B of last valid packet.
- op  out  3  operation of last valid packet.
- err_flags  out  3  {err_data, err_crc, err_op}.
- out_valid  out  1  one-cycle strobe; A/B/op/err_flags are valid while high.
REQ-002 The block SHALL have one clock (clk) and an asynchronous, active-low reset (rst_n).

Function
REQ-003 Frames SHALL be 11 bits, MSB first: start(0), type (0 = DATA, 1 = CMD), payload[7:0], stop(1).
REQ-004 In IDLE, sin==0 at a rising edge SHALL be taken as the start bit. The next 10 edges SHALL sample type, payload[7:0] and stop.
REQ-005 The FSM SHALL have two states: IDLE and RECV.
- RECV SHALL return to IDLE on the edge that samples the stop bit.
- A start bit on the very next edge SHALL be accepted, so back-to-back frames work.
REQ-006 A packet SHALL be 8 DATA frames then 1 CMD frame. DATA bytes arrive in order B[31:24], B[23:16], B[15:8], B[7:0], A[31:24], A[23:16], A[15:8], A[7:0].
REQ-007 The CMD payload SHALL be {0, OP[2:0], CRC[3:0]}.
REQ-008 The expected CRC SHALL be CRC-4, polynomial x^4+x+1, initial value 0, computed over the 68-bit vector {B, A, 1'b1, OP}.
REQ-009 Valid OP values SHALL be 000 (AND), 001 (OR), 100 (ADD) and 101 (SUB); all other values are invalid.
REQ-010 On the stop-bit edge of a CMD frame, out_valid SHALL go high for exactly one cycle, with A, B and op updated on that same edge.
REQ-011 err_flags SHALL be set at the CMD stop-bit edge, with one flag only, in priority order:
- err_data if the DATA count != 8;
- else err_crc if the received CRC != the expected CRC;
- else err_op if OP is invalid;
- else 000.
REQ-012 A 9th DATA frame with no CMD SHALL pulse out_valid with err_flags=100 at its stop-bit edge, and SHALL reset the DATA count to 0.
REQ-013 A stop bit sampled as 0 SHALL discard the current packet, pulse out_valid with err_flags=100, and reset the DATA count to 0.
REQ-014 After any out_valid pulse, the DATA count SHALL be 0 and the next frame SHALL start a new packet.
REQ-015 A, B and op SHALL update only on error-free packets; otherwise they hold their previous value.
REQ-016 err_flags SHALL hold its value until the next out_valid pulse.
REQ-017 Latency from the CMD stop bit present on sin to out_valid high SHALL be 1 clk edge, plus the synchronizer delay of REQ-022 when that feature is enabled.

Reset
REQ-018 While rst_n is low, the FSM SHALL be in IDLE with the bit counter and DATA count at 0.
REQ-019 While rst_n is low, A, B, op, err_flags and out_valid SHALL all be 0.
REQ-020 Reset asserted mid-frame or mid-packet SHALL discard all partial data, with no out_valid pulse generated.
REQ-021 After reset release, the first sin==0 SHALL be treated as a start bit.

Configuration
REQ-022 With macro MTM_ALU_SIN_SYNC_EN defined, sin SHALL pass through a 2-flop synchronizer reset to 1, adding exactly 2 cycles of latency.
REQ-023 Without MTM_ALU_SIN_SYNC_EN, sin SHALL be sampled directly, and all other behaviour is identical.

Verification
REQ-024 The bench SHALL cover these scenarios (stimulus -> required response):
- B=0x22222222, A=0x11111111, OP=100, correct CRC -> one out_valid; A=0x11111111, B=0x22222222, op=100, err_flags=000.
- Same packet with CRC=0000 -> out_valid; err_flags=010; A/B/op unchanged.
- OP=010 with correct CRC -> err_flags=001.
- 9 DATA frames, no CMD -> out_valid at the 9th stop bit, err_flags=100. A following valid packet with A=0xFFFFFFFF, B=0x00000000, OP=000 -> err_flags=000.
- 7 DATA frames then CMD -> err_flags=100. Also: rst_n pulsed low during frame 5, then a full valid packet -> exactly one out_valid, err_flags=000.
- 20 back-to-back valid packets with random A/B and each valid OP -> 20 out_valid pulses, each with matching A/B/op. Run with and without MTM_ALU_SIN_SYNC_EN.

Source files
------------

// File: rtl/mtm_alu_deserializer.sv
// ---------------------------------------------------------------------------
// mtm_alu_deserializer
//
// Receives the serial ALU command stream and rebuilds operand packets.
// A frame is 11 bits, MSB first: start(0), type (0 = DATA, 1 = CMD),
// payload[7:0], stop(1). A packet is eight DATA frames carrying
// B[31:24] .. B[7:0], A[31:24] .. A[7:0], followed by one CMD frame
// carrying {0, OP[2:0], CRC[3:0]}. The CRC is CRC-4 (x^4 + x + 1, init 0)
// over {B, A, 1'b1, OP}.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   sin        in   1   serial input, idles high
//   A          out 32   operand A of the last error-free packet
//   B          out 32   operand B of the last error-free packet
//   op         out  3   operation of the last error-free packet
//   err_flags  out  3   {err_data, err_crc, err_op}, held until next strobe
//   out_valid  out  1   one-cycle strobe marking a packet result
//
// Build option
//   MTM_ALU_SIN_SYNC_EN  when defined, sin goes through a 2-flop synchronizer
//                        (reset to 1), adding two cycles of latency.
//
// State table
//   state  | meaning
//   IDLE   | waiting for a start bit (sin == 0)
//   RECV   | sampling type, payload[7:0] and stop; leaves on the stop edge
// ---------------------------------------------------------------------------
module mtm_alu_deserializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  op,
    output logic [2:0]  err_flags,
    output logic        out_valid
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    localparam logic [3:0] STOP_IDX   = 4'd9;
    localparam logic [3:0] DATA_BYTES = 4'd8;

    localparam logic [2:0] ERR_NONE = 3'b000;
    localparam logic [2:0] ERR_DATA = 3'b100;
    localparam logic [2:0] ERR_CRC  = 3'b010;
    localparam logic [2:0] ERR_OP   = 3'b001;

    state_t      state_q,    state_d;
    logic [3:0]  bit_cnt_q,  bit_cnt_d;
    logic [8:0]  frame_q,    frame_d;
    logic [3:0]  data_cnt_q, data_cnt_d;
    logic [63:0] data_q,     data_d;
    logic [31:0] a_q,        a_d;
    logic [31:0] b_q,        b_d;
    logic [2:0]  op_q,       op_d;
    logic [2:0]  err_q,      err_d;
    logic        valid_q,    valid_d;

    logic        sin_s;
    logic        stop_edge;
    logic        frame_is_cmd;
    logic [2:0]  rx_op;
    logic [3:0]  rx_crc;
    logic [3:0]  exp_crc;
    logic        op_ok;

    // -----------------------------------------------------------------------
    // Serial input conditioning
    // -----------------------------------------------------------------------
`ifdef MTM_ALU_SIN_SYNC_EN
    logic [1:0] sync_q;

    // Reset to 1 so the synchronizer never fabricates a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], sin};
        end
    end

    assign sin_s = sync_q[1];
`else
    assign sin_s = sin;
`endif

    // -----------------------------------------------------------------------
    // CRC-4, polynomial x^4 + x + 1, initial value 0, MSB first
    // -----------------------------------------------------------------------
    function automatic logic [3:0] crc4(input logic [67:0] din);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ din[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    // frame_q holds {type, payload[7:0]} once the stop bit is being sampled.
    assign stop_edge    = (state_q == S_RECV) && (bit_cnt_q == STOP_IDX);
    assign frame_is_cmd = frame_q[8];
    assign rx_op        = frame_q[6:4];
    assign rx_crc       = frame_q[3:0];
    assign exp_crc      = crc4({data_q, 1'b1, rx_op});
    assign op_ok        = (rx_op == 3'b000) || (rx_op == 3'b001) ||
                          (rx_op == 3'b100) || (rx_op == 3'b101);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (!sin_s) begin
                state_d = S_RECV;
            end
        end else if (stop_edge) begin
            // Back to IDLE on the stop edge so the very next edge can be a start bit.
            state_d = S_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs and datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        data_cnt_d = data_cnt_q;
        data_d     = data_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        err_d      = err_q;
        valid_d    = 1'b0;

        if (state_q == S_IDLE) begin
            bit_cnt_d = 4'd0;
        end else if (!stop_edge) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            frame_d   = {frame_q[7:0], sin_s};
        end else begin
            bit_cnt_d = 4'd0;
            if (!sin_s) begin
                // Framing error: drop the whole packet.
                valid_d    = 1'b1;
                err_d      = ERR_DATA;
                data_cnt_d = 4'd0;
            end else if (!frame_is_cmd) begin
                if (data_cnt_q == DATA_BYTES) begin
                    // Ninth DATA frame without a CMD.
                    valid_d    = 1'b1;
                    err_d      = ERR_DATA;
                    data_cnt_d = 4'd0;
                end else begin
                    data_d     = {data_q[55:0], frame_q[7:0]};
                    data_cnt_d = data_cnt_q + 4'd1;
                end
            end else begin
                valid_d    = 1'b1;
                data_cnt_d = 4'd0;
                if (data_cnt_q != DATA_BYTES) begin
                    err_d = ERR_DATA;
                end else if (rx_crc != exp_crc) begin
                    err_d = ERR_CRC;
                end else if (!op_ok) begin
                    err_d = ERR_OP;
                end else begin
                    err_d = ERR_NONE;
                    b_d   = data_q[63:32];
                    a_d   = data_q[31:0];
                    op_d  = rx_op;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= 4'd0;
            frame_q    <= 9'd0;
            data_cnt_q <= 4'd0;
            data_q     <= 64'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            op_q       <= 3'd0;
            err_q      <= 3'd0;
            valid_q    <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            data_cnt_q <= data_cnt_d;
            data_q     <= data_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign op        = op_q;
    assign err_flags = err_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sin;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic [2:0]  err_flags;
    logic        out_valid;

`ifdef MTM_ALU_SIN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    mtm_alu_deserializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .A         (A),
        .B         (B),
        .op        (op),
        .err_flags (err_flags),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  err;
        int          cyc;
    } obs_t;

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        bit          bad_crc;
        int          ndata;
        bit          cmd;
        logic [2:0]  e_err;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [2:0]  e_op;
    } vec_t;

    obs_t obs_q[$];
    obs_t exp_q[$];
    vec_t vecs[8];

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int last_bit_cyc  = 0;
    int last_stop_cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Pulse monitor: one record per cycle with out_valid high.
    always @(posedge clk) begin
        obs_t o;
        #1;
        if (out_valid === 1'b1) begin
            o.a = A; o.b = B; o.op = op; o.err = err_flags; o.cyc = cyc;
            obs_q.push_back(o);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference CRC by long division of {B, A, 1, OP, 0000} by 10011.
    function automatic logic [3:0] crc_ref(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] o);
        logic [71:0] r;
        r = {b, a, 1'b1, o, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    task automatic send_bit(input logic v);
        @(negedge clk);
        sin = v;
        last_bit_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stp);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(pl[i]);
        send_bit(stp);
        last_stop_cyc = last_bit_cyc;
    endtask

    task automatic send_pkt(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o,
                            input logic [3:0] crc, input int ndata, input bit cmd);
        logic [63:0] d;
        d = {b, a};
        for (int k = 0; k < ndata; k++) begin
            if (k < 8) send_frame(1'b0, d[63 - 8*k -: 8], 1'b1);
            else       send_frame(1'b0, 8'h55, 1'b1);
        end
        if (cmd) send_frame(1'b1, {1'b0, o, crc}, 1'b1);
    endtask

    task automatic chk_ports(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                             input logic [2:0] eo, input logic [2:0] ee);
        chk({tag, " A"},   A,         ea);
        chk({tag, " B"},   B,         eb);
        chk({tag, " op"},  op,        eo);
        chk({tag, " err"}, err_flags, ee);
    endtask

    initial begin
        int n0;
        logic [3:0] crc;
        logic [2:0] ops[4];

        //            b             a             op      bad ndata cmd err     e_a           e_b           e_op
        vecs[0] = '{32'h22222222, 32'h11111111, 3'b100, 1'b0, 8, 1'b1, 3'b000, 32'h11111111, 32'h22222222, 3'b100};
        vecs[1] = '{32'h22222222, 32'h11111111, 3'b100, 1'b1, 8, 1'b1, 3'b010, 32'h11111111, 32'h22222222, 3'b100};
        vecs[2] = '{32'h22222222, 32'h11111111, 3'b010, 1'b0, 8, 1'b1, 3'b001, 32'h11111111, 32'h22222222, 3'b100};
        vecs[3] = '{32'h33333333, 32'h44444444, 3'b000, 1'b0, 9, 1'b0, 3'b100, 32'h11111111, 32'h22222222, 3'b100};
        vecs[4] = '{32'h00000000, 32'hFFFFFFFF, 3'b000, 1'b0, 8, 1'b1, 3'b000, 32'hFFFFFFFF, 32'h00000000, 3'b000};
        vecs[5] = '{32'h12121212, 32'h34343434, 3'b001, 1'b0, 7, 1'b1, 3'b100, 32'hFFFFFFFF, 32'h00000000, 3'b000};
        vecs[6] = '{32'hDEADBEEF, 32'h12345678, 3'b001, 1'b0, 8, 1'b1, 3'b000, 32'h12345678, 32'hDEADBEEF, 3'b001};
        vecs[7] = '{32'h00000001, 32'h00000002, 3'b101, 1'b0, 8, 1'b1, 3'b000, 32'h00000002, 32'h00000001, 3'b101};

        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b101;

        // Reset state
        rst_n = 1'b0;
        sin   = 1'b1;
        repeat (3) @(negedge clk);
        chk_ports("reset", 32'd0, 32'd0, 3'd0, 3'd0);
        chk("reset out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        idle(3);

        // Table-driven packets
        for (int v = 0; v < 8; v++) begin
            n0  = obs_q.size();
            crc = vecs[v].bad_crc ? 4'h0 : crc_ref(vecs[v].b, vecs[v].a, vecs[v].op);
            send_pkt(vecs[v].b, vecs[v].a, vecs[v].op, crc, vecs[v].ndata, vecs[v].cmd);
            idle(6);
            chk($sformatf("vec%0d pulses", v), obs_q.size() - n0, 1);
            if (obs_q.size() > n0) begin
                chk($sformatf("vec%0d pulse err", v), obs_q[n0].err, vecs[v].e_err);
                chk($sformatf("vec%0d latency", v), obs_q[n0].cyc, last_stop_cyc + LAT);
            end
            chk_ports($sformatf("vec%0d", v), vecs[v].e_a, vecs[v].e_b, vecs[v].e_op, vecs[v].e_err);
        end

        // Stop bit sampled as 0 discards the partial packet and clears the DATA count.
        n0 = obs_q.size();
        send_frame(1'b0, 8'hA1, 1'b1);
        send_frame(1'b0, 8'hA2, 1'b1);
        send_frame(1'b0, 8'hA3, 1'b0);
        idle(6);
        chk("badstop pulses", obs_q.size() - n0, 1);
        chk_ports("badstop", 32'h00000002, 32'h00000001, 3'b101, 3'b100);
        n0 = obs_q.size();
        send_pkt(32'hCAFEF00D, 32'h0BADBEEF, 3'b100, crc_ref(32'hCAFEF00D, 32'h0BADBEEF, 3'b100), 8, 1'b1);
        idle(6);
        chk("after badstop pulses", obs_q.size() - n0, 1);
        chk_ports("after badstop", 32'h0BADBEEF, 32'hCAFEF00D, 3'b100, 3'b000);

        // Reset in the middle of frame 5, then a clean packet.
        n0 = obs_q.size();
        send_pkt(32'h01020304, 32'h05060708, 3'b000, 4'h0, 4, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        sin   = 1'b1;
        repeat (2) @(negedge clk);
        chk_ports("midreset", 32'd0, 32'd0, 3'd0, 3'd0);
        chk("midreset out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        idle(2);
        chk("midreset no pulse", obs_q.size() - n0, 0);
        n0 = obs_q.size();
        send_pkt(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b001, crc_ref(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b001), 8, 1'b1);
        idle(6);
        chk("postreset pulses", obs_q.size() - n0, 1);
        chk_ports("postreset", 32'h5A5A5A5A, 32'hA5A5A5A5, 3'b001, 3'b000);

        // 20 back-to-back packets
        n0 = obs_q.size();
        for (int i = 0; i < 20; i++) begin
            obs_t e;
            e.a = $urandom;
            e.b = $urandom;
            e.op = ops[i % 4];
            e.err = 3'b000;
            send_pkt(e.b, e.a, e.op, crc_ref(e.b, e.a, e.op), 8, 1'b1);
            e.cyc = last_stop_cyc + LAT;
            exp_q.push_back(e);
        end
        idle(6);
        chk("b2b pulses", obs_q.size() - n0, 20);
        for (int i = 0; i < 20; i++) begin
            if (n0 + i < obs_q.size()) begin
                chk($sformatf("b2b%0d A", i),   obs_q[n0+i].a,   exp_q[i].a);
                chk($sformatf("b2b%0d B", i),   obs_q[n0+i].b,   exp_q[i].b);
                chk($sformatf("b2b%0d op", i),  obs_q[n0+i].op,  exp_q[i].op);
                chk($sformatf("b2b%0d err", i), obs_q[n0+i].err, exp_q[i].err);
                chk($sformatf("b2b%0d cyc", i), obs_q[n0+i].cyc, exp_q[i].cyc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
